// File: rtl/and_gate.sv
// Bitwise 2-input AND with a registered copy, reduction flags and rising-edge pulses.
// Optional saturating activity counter on hi_cnt, enabled by AND_GATE_STATS_EN.
module and_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             y_all,
   output logic             y_any,
   output logic [WIDTH-1:0] rise,
   output logic [CNT_W-1:0] hi_cnt
);

   assign y = a & b;

   // Reset clears y_q, so the first sample after release sees every set bit as a rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q   <= '0;
         y_all <= 1'b0;
         y_any <= 1'b0;
         rise  <= '0;
      end else begin
         y_q   <= y;
         y_all <= &y;
         y_any <= |y;
         rise  <= y & ~y_q;
      end
   end

`ifdef AND_GATE_STATS_EN
   logic [CNT_W-1:0] cnt_q;

   // Counts the current sample, not the registered y_any, and holds at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if ((|y) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign hi_cnt = cnt_q;
`else
   assign hi_cnt = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: combinational checks on a WIDTH=1 instance with an idle clock,
// scoreboarded registered checks on a WIDTH=4, CNT_W=2 instance.
module tb_and_gate;

   typedef struct packed {
      logic [3:0] y_q;
      logic       y_all;
      logic       y_any;
      logic [3:0] rise;
      logic [1:0] hi_cnt;
   } exp_t;

`ifdef AND_GATE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   logic        clk  = 1'b0;
   logic        clk1 = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst1_n = 1'b1;
   logic [0:0]  a1 = '0, b1 = '0;
   logic [0:0]  y1, y1_q, rise1;
   logic        y1_all, y1_any;
   logic [15:0] hi1_cnt;

   logic [3:0]  a4 = '0, b4 = '0;
   logic [3:0]  y4, y4_q, rise4;
   logic        y4_all, y4_any;
   logic [1:0]  hi4_cnt;

   exp_t sb[$];

   and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
      .clk(clk1), .rst_n(rst1_n), .a(a1), .b(b1), .y(y1), .y_q(y1_q),
      .y_all(y1_all), .y_any(y1_any), .rise(rise1), .hi_cnt(hi1_cnt)
   );

   and_gate #(.WIDTH(4), .CNT_W(2)) u4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .y(y4), .y_q(y4_q),
      .y_all(y4_all), .y_any(y4_any), .rise(rise4), .hi_cnt(hi4_cnt)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every edge presents a result; compare it against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("y_q",    16'(y4_q),    16'(e.y_q));
            check("y_all",  16'(y4_all),  16'(e.y_all));
            check("y_any",  16'(y4_any),  16'(e.y_any));
            check("rise",   16'(rise4),   16'(e.rise));
            check("hi_cnt", 16'(hi4_cnt), 16'(e.hi_cnt));
         end
      end
   end

   task automatic comb1(input logic a, input logic b, input logic ey);
      a1 = a;
      b1 = b;
      #1;
      check("y_w1", 16'(y1), 16'(ey));
      #9;
   endtask

   task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ey, input logic [3:0] eyq, input logic eall,
                       input logic eany, input logic [3:0] erise, input logic [1:0] ecnt);
      exp_t e;
      @(negedge clk);
      rst_n = rst;
      a4 = a;
      b4 = b;
      #1;
      check("y_w4", 16'(y4), 16'(ey));
      e.y_q    = eyq;
      e.y_all  = eall;
      e.y_any  = eany;
      e.rise   = erise;
      e.hi_cnt = STATS ? ecnt : 2'd0;
      sb.push_back(e);
   endtask

   initial begin
      comb1(1'b0, 1'b0, 1'b0);
      comb1(1'b0, 1'b1, 1'b0);
      comb1(1'b1, 1'b0, 1'b0);
      comb1(1'b1, 1'b1, 1'b1);

      //   rst a     b     y     y_q   all  any  rise  cnt
      step(0, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0, 4'h0, 2'd0);
      step(0, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0, 4'h0, 2'd0);
      step(1, 4'hF, 4'hA, 4'hA, 4'hA, 0, 1, 4'hA, 2'd1);
      step(1, 4'hF, 4'hA, 4'hA, 4'hA, 0, 1, 4'h0, 2'd2);
      step(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0, 4'h0, 2'd2);
      step(1, 4'h3, 4'hF, 4'h3, 4'h3, 0, 1, 4'h3, 2'd3);
      step(1, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'hC, 2'd3);
      step(1, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 2'd3);
      step(0, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0, 4'h0, 2'd0);
      step(1, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'hF, 2'd1);
      step(1, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 2'd2);
      step(1, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 2'd3);
      step(1, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 2'd3);
      step(1, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 2'd3);
      step(0, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0, 4'h0, 2'd0);
      step(1, 4'h5, 4'h6, 4'h4, 4'h4, 0, 1, 4'h4, 2'd1);
      step(1, 4'h8, 4'h8, 4'h8, 4'h8, 0, 1, 4'h8, 2'd2);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: actual=%0d pending required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
